object_locator: RTL

//  Parametrised successor to the single-channel accumulator on the detection path. Consumes the

---
 rtl/object_locator.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/object_locator.sv
// object_locator: per-frame bounding box, hit count and centroid of all pixels
// whose value is at or above a threshold latched at start of frame.
//
// Optional feature macro: CENTROID_EN
//   defined   : centroid = sum / count via a serial restoring divider (X_W steps)
//   undefined : centroid = midpoint of the bounding box, result one cycle after eof
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   sof_i, eof_i   start/end of frame strobes
//   pix_valid_i    qualifies pix_x_i / pix_y_i / pix_val_i
//   thresh_i       hit threshold, sampled on sof_i
//   busy_o         frame accumulation or division in progress
//   result_valid_o one-cycle pulse, all result outputs updated together
//   found_o        hit_count_o >= MIN_COUNT
//   hit_count_o    hits in the last completed frame (saturating)
//   min/max_x_o/_y_o  bounding box, zero when not found
//   cen_x_o/cen_y_o   centroid, zero when not found
//   overrun_o      sticky: stream activity seen while dividing
module object_locator #(
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 9,
    parameter int unsigned PIX_W     = 4,
    parameter int unsigned MIN_COUNT = 16,
    parameter int unsigned CNT_W     = X_W + Y_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             sof_i,
    input  logic             eof_i,
    input  logic             pix_valid_i,
    input  logic [X_W-1:0]   pix_x_i,
    input  logic [Y_W-1:0]   pix_y_i,
    input  logic [PIX_W-1:0] pix_val_i,
    input  logic [PIX_W-1:0] thresh_i,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic             found_o,
    output logic [CNT_W-1:0] hit_count_o,
    output logic [X_W-1:0]   min_x_o,
    output logic [X_W-1:0]   max_x_o,
    output logic [Y_W-1:0]   min_y_o,
    output logic [Y_W-1:0]   max_y_o,
    output logic [X_W-1:0]   cen_x_o,
    output logic [Y_W-1:0]   cen_y_o,
    output logic             overrun_o
);

    localparam int unsigned XS_W = X_W + 1;
    localparam int unsigned YS_W = Y_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DIVIDE = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   clr_c, acc_c, fin_c, hit_c;
    logic   busy_q;

    logic [PIX_W-1:0] thr_q;
    logic [CNT_W-1:0] cnt_q, cnt_fin;
    logic [X_W-1:0]   min_x_q, max_x_q, min_x_fin, max_x_fin;
    logic [Y_W-1:0]   min_y_q, max_y_q, min_y_fin, max_y_fin;

    // Publish mux: values captured into the result registers
    logic             pub_c;
    logic             pub_found;
    logic [CNT_W-1:0] pub_cnt;
    logic [X_W-1:0]   pub_min_x, pub_max_x, pub_cx;
    logic [Y_W-1:0]   pub_min_y, pub_max_y, pub_cy;

    // Result registers
    logic             rv_q, found_q;
    logic [CNT_W-1:0] hc_q;
    logic [X_W-1:0]   rmin_x_q, rmax_x_q, cx_q;
    logic [Y_W-1:0]   rmin_y_q, rmax_y_q, cy_q;

`ifdef CENTROID_EN
    localparam int unsigned SX_W = CNT_W + X_W;
    localparam int unsigned SY_W = CNT_W + Y_W;
    localparam int unsigned IT_W = $clog2(X_W);

    logic            div_done_c;
    logic [SX_W-1:0] sum_x_q, sum_x_fin;
    logic [SY_W-1:0] sum_y_q, sum_y_fin;
    logic [SX_W-1:0] rem_x_q, rem_y_q, rem_x_d, rem_y_d, div_q;
    logic [X_W-1:0]  qx_q, qy_q, qx_d, qy_d;
    logic [IT_W-1:0] it_q;
    logic            ovr_q;
`endif

    assign hit_c = acc_c && pix_valid_i && (pix_val_i >= thr_q);

    // Accumulator values including the current cycle's pixel (covers the eof cycle)
    always_comb begin
        cnt_fin   = cnt_q;
        min_x_fin = min_x_q;
        max_x_fin = max_x_q;
        min_y_fin = min_y_q;
        max_y_fin = max_y_q;
        if (hit_c) begin
            if (cnt_q != '1)       cnt_fin   = cnt_q + CNT_W'(1);
            if (pix_x_i < min_x_q) min_x_fin = pix_x_i;
            if (pix_x_i > max_x_q) max_x_fin = pix_x_i;
            if (pix_y_i < min_y_q) min_y_fin = pix_y_i;
            if (pix_y_i > max_y_q) max_y_fin = pix_y_i;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        clr_c   = 1'b0;
        acc_c   = 1'b0;
        fin_c   = 1'b0;
`ifdef CENTROID_EN
        div_done_c = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (sof_i) begin
                    clr_c   = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (sof_i) begin
                    clr_c = 1'b1;
                end else begin
                    acc_c = 1'b1;
                    if (eof_i) begin
                        fin_c = 1'b1;
`ifdef CENTROID_EN
                        state_d = S_DIVIDE;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
`ifdef CENTROID_EN
            S_DIVIDE: begin
                if (it_q == IT_W'(X_W - 1)) begin
                    div_done_c = 1'b1;
                    state_d    = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Frame accumulators
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            thr_q <= '0;
        end else if (clr_c) begin
            thr_q <= thresh_i;
        end
        if (reset_i || clr_c) begin
            cnt_q   <= '0;
            min_x_q <= '1;
            max_x_q <= '0;
            min_y_q <= '1;
            max_y_q <= '0;
        end else if (acc_c) begin
            cnt_q   <= cnt_fin;
            min_x_q <= min_x_fin;
            max_x_q <= max_x_fin;
            min_y_q <= min_y_fin;
            max_y_q <= max_y_fin;
        end
    end

`ifdef CENTROID_EN
    assign sum_x_fin = hit_c ? (sum_x_q + SX_W'(pix_x_i)) : sum_x_q;
    assign sum_y_fin = hit_c ? (sum_y_q + SY_W'(pix_y_i)) : sum_y_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_c) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
        end else if (acc_c) begin
            sum_x_q <= sum_x_fin;
            sum_y_q <= sum_y_fin;
        end
    end

    // Restoring step: quotient < 2^X_W, so the divisor starts at count << (X_W-1)
    always_comb begin
        rem_x_d = rem_x_q;
        rem_y_d = rem_y_q;
        qx_d    = qx_q << 1;
        qy_d    = qy_q << 1;
        if (rem_x_q >= div_q) begin
            rem_x_d = rem_x_q - div_q;
            qx_d    = (qx_q << 1) | X_W'(1);
        end
        if (rem_y_q >= div_q) begin
            rem_y_d = rem_y_q - div_q;
            qy_d    = (qy_q << 1) | X_W'(1);
        end
    end

    // Serial divider datapath
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rem_x_q <= '0;
            rem_y_q <= '0;
            div_q   <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            it_q    <= '0;
        end else if (fin_c) begin
            rem_x_q <= SX_W'(sum_x_fin);
            rem_y_q <= SX_W'(sum_y_fin);
            div_q   <= SX_W'(cnt_fin) << (X_W - 1);
            qx_q    <= '0;
            qy_q    <= '0;
            it_q    <= '0;
        end else if (state_q == S_DIVIDE) begin
            rem_x_q <= rem_x_d;
            rem_y_q <= rem_y_d;
            div_q   <= div_q >> 1;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            it_q    <= it_q + IT_W'(1);
        end
    end

    // Sticky overrun: stream activity while the divider owns the accumulators
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ovr_q <= 1'b0;
        end else if ((state_q == S_DIVIDE) && (pix_valid_i || sof_i || eof_i)) begin
            ovr_q <= 1'b1;
        end
    end
    assign overrun_o = ovr_q;

    assign pub_c     = div_done_c;
    assign pub_cnt   = cnt_q;
    assign pub_min_x = min_x_q;
    assign pub_max_x = max_x_q;
    assign pub_min_y = min_y_q;
    assign pub_max_y = max_y_q;
    assign pub_cx    = X_W'(qx_d);
    assign pub_cy    = Y_W'(qy_d);
`else
    assign overrun_o = 1'b0;

    assign pub_c     = fin_c;
    assign pub_cnt   = cnt_fin;
    assign pub_min_x = min_x_fin;
    assign pub_max_x = max_x_fin;
    assign pub_min_y = min_y_fin;
    assign pub_max_y = max_y_fin;
    // Bounding-box midpoint with a one-bit-wider sum
    assign pub_cx    = X_W'((XS_W'(min_x_fin) + XS_W'(max_x_fin)) >> 1);
    assign pub_cy    = Y_W'((YS_W'(min_y_fin) + YS_W'(max_y_fin)) >> 1);
`endif

    assign pub_found = (pub_cnt >= CNT_W'(MIN_COUNT));

    // Result registers: hold until the next publish; box/centroid zeroed when not found
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rv_q     <= 1'b0;
            found_q  <= 1'b0;
            hc_q     <= '0;
            rmin_x_q <= '0;
            rmax_x_q <= '0;
            rmin_y_q <= '0;
            rmax_y_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
        end else begin
            rv_q <= pub_c;
            if (pub_c) begin
                found_q  <= pub_found;
                hc_q     <= pub_cnt;
                rmin_x_q <= pub_found ? pub_min_x : '0;
                rmax_x_q <= pub_found ? pub_max_x : '0;
                rmin_y_q <= pub_found ? pub_min_y : '0;
                rmax_y_q <= pub_found ? pub_max_y : '0;
                cx_q     <= pub_found ? pub_cx    : '0;
                cy_q     <= pub_found ? pub_cy    : '0;
            end
        end
    end

    assign busy_o         = busy_q;
    assign result_valid_o = rv_q;
    assign found_o        = found_q;
    assign hit_count_o    = hc_q;
    assign min_x_o        = rmin_x_q;
    assign max_x_o        = rmax_x_q;
    assign min_y_o        = rmin_y_q;
    assign max_y_o        = rmax_y_q;
    assign cen_x_o        = cx_q;
    assign cen_y_o        = cy_q;

endmodule
